f_fetch_stage: RTL and testbench

//  F-stage program counter plus F/D pipeline register of the 5-stage MIPS core.

---
 rtl/f_fetch_stage.sv | 67 ++++++
 tb/tb_f_fetch_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/f_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : f_fetch_stage
// Brief   : F-stage program counter and F/D pipeline register of the MIPS core.
// Revision: 1.0
// ============================================================================
module f_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Npc,
  input  logic        Stall,
  input  logic        D_Clr,
  input  logic [31:0] IM_Rdata,
  output logic [31:0] F_PC,
  output logic        F_AdEL,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_Valid,
  output logic        D_AdEL
);

  // Upper fetch bound kept in 33 bits so a base near the top of memory cannot wrap.
  localparam logic [32:0] C_IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic w_misaligned;
  logic w_below_base;
  logic w_above_limit;

  assign w_misaligned  = (F_PC[1:0] != 2'b00);
  assign w_below_base  = (F_PC < IM_BASE);
  assign w_above_limit = ({1'b0, F_PC} >= C_IM_LIMIT);
  assign F_AdEL        = w_misaligned | w_below_base | w_above_limit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_PC <= PC_RESET;
    end else if (!Stall) begin
      F_PC <= Npc;
    end
  end

  // Bubble insertion outranks stall; a faulting fetch forwards a nop plus the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      D_PC    <= PC_RESET;
      D_Instr <= 32'h0;
      D_Valid <= 1'b0;
      D_AdEL  <= 1'b0;
    end else if (D_Clr) begin
      D_PC    <= F_PC;
      D_Instr <= 32'h0;
      D_Valid <= 1'b0;
      D_AdEL  <= 1'b0;
    end else if (!Stall) begin
      D_PC    <= F_PC;
      D_Instr <= F_AdEL ? 32'h0 : IM_Rdata;
      D_Valid <= 1'b1;
      D_AdEL  <= F_AdEL;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_f_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_f_fetch_stage
// Brief   : Directed plus randomized checks of f_fetch_stage against a reference model.
// Revision: 1.0
// ============================================================================
module tb_f_fetch_stage;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_BASE  = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc;
  logic        stall;
  logic        d_clr;
  logic [31:0] im_rdata;
  logic [31:0] f_pc;
  logic        f_adel;
  logic [31:0] d_pc;
  logic [31:0] d_instr;
  logic        d_valid;
  logic        d_adel;

  f_fetch_stage #(
    .PC_RESET(PC_RESET),
    .IM_BASE (IM_BASE),
    .IM_WORDS(IM_WORDS)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .Npc     (npc),
    .Stall   (stall),
    .D_Clr   (d_clr),
    .IM_Rdata(im_rdata),
    .F_PC    (f_pc),
    .F_AdEL  (f_adel),
    .D_PC    (d_pc),
    .D_Instr (d_instr),
    .D_Valid (d_valid),
    .D_AdEL  (d_adel)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [IM_WORDS];

  function automatic logic [31:0] imem(input logic [31:0] pc);
    longint p;
    p = longint'(pc);
    if (p >= longint'(IM_BASE) && p < longint'(IM_BASE) + 4 * IM_WORDS)
      return mem[int'((pc - IM_BASE) >> 2)];
    return 32'hDEAD_BEEF;
  endfunction

  assign im_rdata = imem(f_pc);

  function automatic logic exp_adel(input logic [31:0] pc);
    longint p;
    p = longint'(pc);
    return (p % 4 != 0) || (p < longint'(IM_BASE)) || (p >= longint'(IM_BASE) + 4 * IM_WORDS);
  endfunction

  // Reference state: what each architectural register should hold.
  logic [31:0] m_fpc, m_dpc, m_dinstr;
  logic        m_dvalid, m_dadel;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".F_PC"},    f_pc,           m_fpc);
    check({tag, ".F_AdEL"},  32'(f_adel),    32'(exp_adel(m_fpc)));
    check({tag, ".D_PC"},    d_pc,           m_dpc);
    check({tag, ".D_Instr"}, d_instr,        m_dinstr);
    check({tag, ".D_Valid"}, 32'(d_valid),   32'(m_dvalid));
    check({tag, ".D_AdEL"},  32'(d_adel),    32'(m_dadel));
  endtask

  task automatic model_reset();
    m_fpc    = PC_RESET;
    m_dpc    = PC_RESET;
    m_dinstr = 32'h0;
    m_dvalid = 1'b0;
    m_dadel  = 1'b0;
  endtask

  task automatic model_edge();
    logic fault;
    fault = exp_adel(m_fpc);
    if (d_clr) begin
      m_dpc = m_fpc; m_dinstr = 32'h0; m_dvalid = 1'b0; m_dadel = 1'b0;
    end else if (!stall) begin
      m_dpc = m_fpc; m_dinstr = fault ? 32'h0 : imem(m_fpc); m_dvalid = 1'b1; m_dadel = fault;
    end
    if (!stall) m_fpc = npc;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Reset asserted between edges must act at once; released on a falling edge.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < IM_WORDS; i++) mem[i] = $urandom;
    for (int i = 0; i < 8; i++) mem[i] = 32'h3C01_0001;

    reset = 1'b0; stall = 1'b0; d_clr = 1'b0; npc = 32'h0;
    #2 reset = 1'b1;
    #1 model_reset();
    check_all("reset_no_clk");
    @(negedge clk);
    reset = 1'b0;

    npc = m_fpc + 4; cycle("straight1");
    npc = m_fpc + 4; cycle("straight2");
    check("straight2.F_PC_0x3008", f_pc, 32'h3008);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      npc = 32'h3080; cycle("stall");
    end
    check("stall.F_PC_held", f_pc, 32'h3008);
    stall = 1'b0; npc = 32'h300C; cycle("stall_release");

    stall = 1'b1; d_clr = 1'b1; npc = 32'h3090; cycle("stall_clr");
    check("stall_clr.D_PC_0x300C", d_pc, 32'h300C);
    stall = 1'b0; d_clr = 1'b0; npc = 32'h3010; cycle("after_clr");

    npc = 32'h3100; cycle("jump");
    check("jump.D_PC_delay_slot", d_pc, 32'h3010);
    npc = 32'h3104; cycle("jump_target");
    check("jump_target.D_PC", d_pc, 32'h3100);

    npc = 32'h3002; cycle("misaligned");
    npc = 32'h7000; cycle("misaligned_in_D");
    npc = 32'h6FFC; cycle("past_limit");
    npc = 32'h2FFC; cycle("last_word");
    npc = 32'h3000; cycle("below_base");
    npc = 32'h3004; cycle("back_in_range");

    stall = 1'b1;
    async_reset("reset_mid_stall");
    stall = 1'b0;

    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 70)      npc = m_fpc + 4;
      else if (r < 85) npc = IM_BASE + 4 * $urandom_range(0, IM_WORDS - 1);
      else if (r < 92) npc = $urandom;
      else             npc = IM_BASE - 8 + $urandom_range(0, 4 * IM_WORDS + 16);
      stall = ($urandom_range(0, 99) < 20);
      d_clr = ($urandom_range(0, 99) < 10);
      cycle("random");
      if ($urandom_range(0, 99) < 2) async_reset("random_reset");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
